// File: rtl/cpu_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_pkg
// Purpose  : Shared fetch-stage types: assembler states and decoded record.
// Revision : 1.0 - initial release
// ============================================================================
package cpu_pkg;

    localparam int         CPU_ADDR_W = 16;
    localparam logic [4:0] OPC_HLT    = 5'b11111;

    typedef enum logic [1:0] {
        OP   = 2'd0,
        REG  = 2'd1,
        IMM1 = 2'd2,
        IMM2 = 2'd3
    } FetchState;

    typedef struct packed {
        logic [4:0]            opcode;
        logic [2:0]            dst;
        logic                  hasimm1;
        logic                  hasimm2;
        logic [2:0]            src1;
        logic [2:0]            src2;
        logic [7:0]            imm1;
        logic [7:0]            imm2;
        logic [CPU_ADDR_W-1:0] pc;
        logic [CPU_ADDR_W-1:0] next_pc;
    } instr_rec_t;

    function automatic instr_rec_t build_rec(
        input logic [7:0]            byte0,
        input logic [7:0]            byte1,
        input logic [7:0]            imm1,
        input logic [7:0]            imm2,
        input logic [CPU_ADDR_W-1:0] pc,
        input logic [CPU_ADDR_W-1:0] next_pc
    );
        instr_rec_t r;
        r.opcode  = byte0[4:0];
        r.dst     = byte0[7:5];
        r.hasimm1 = byte1[7];
        r.hasimm2 = byte1[6];
        r.src1    = byte1[5:3];
        r.src2    = byte1[2:0];
        r.imm1    = imm1;
        r.imm2    = imm2;
        r.pc      = pc;
        r.next_pc = next_pc;
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/instr_queue.sv
`default_nettype none
// ============================================================================
// Module   : instr_queue
// Purpose  : DEPTH-entry FIFO of decoded records with push/pop/flush.
// Revision : 1.0 - initial release
// ============================================================================
module instr_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  instr_rec_t       data_i,
    input  logic             pop_i,
    input  logic             flush_i,
    output instr_rec_t       head_o,
    output logic [CNT_W-1:0] count_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int               PTR_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [PTR_W-1:0] C_LAST = PTR_W'(DEPTH - 1);

    logic [PTR_W-1:0] rd_ptr_q;
    logic [PTR_W-1:0] wr_ptr_q;
    logic [CNT_W-1:0] count_q;
    instr_rec_t       w_entries [DEPTH];
    logic             w_pop;
    logic             w_push;

    assign w_pop  = pop_i & ~empty_o;
    assign w_push = push_i & (~full_o | w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (flush_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (w_push) wr_ptr_q <= (wr_ptr_q == C_LAST) ? '0 : wr_ptr_q + 1'b1;
            if (w_pop)  rd_ptr_q <= (rd_ptr_q == C_LAST) ? '0 : rd_ptr_q + 1'b1;
            unique case ({w_push, w_pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    // Entries are zeroed on flush so the head fields read 0 afterwards.
    for (genvar i = 0; i < DEPTH; i++) begin : g_entry
        instr_rec_t entry_q;
        always_ff @(posedge clk or posedge rst) begin
            if (rst)
                entry_q <= '0;
            else if (flush_i)
                entry_q <= '0;
            else if (w_push && (wr_ptr_q == PTR_W'(i)))
                entry_q <= data_i;
        end
        assign w_entries[i] = entry_q;
    end

    assign head_o  = w_entries[rd_ptr_q];
    assign count_o = count_q;
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);

endmodule
`default_nettype wire

// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_unit
// Purpose  : Byte-serial instruction fetch/assembler feeding a record queue.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_unit
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 16,
    parameter int DEPTH  = 2
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] rom_addr,
    input  logic [7:0]        rom_data,
    input  logic              halt,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_pc,
    output logic              ins_valid,
    input  logic              ins_ready,
    output logic [4:0]        ins_opcode,
    output logic [2:0]        ins_dst,
    output logic              ins_hasimm1,
    output logic              ins_hasimm2,
    output logic [2:0]        ins_src1,
    output logic [2:0]        ins_src2,
    output logic [7:0]        ins_imm1,
    output logic [7:0]        ins_imm2,
    output logic [ADDR_W-1:0] ins_pc,
    output logic [ADDR_W-1:0] ins_next_pc
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    if (ADDR_W != CPU_ADDR_W) begin : g_addr_w_check
        $error("instr_fetch_unit: ADDR_W must equal cpu_pkg::CPU_ADDR_W");
    end

    FetchState         state_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] start_pc_q;
    logic [7:0]        byte0_q;
    logic [7:0]        byte1_q;
    logic [7:0]        imm1_q;

    logic [7:0]        w_byte1;
    logic [7:0]        w_imm1;
    logic [7:0]        w_imm2;
    logic              w_complete;
    logic [ADDR_W-1:0] w_pc_inc;
    instr_rec_t        w_rec;
    instr_rec_t        w_head;
    logic [CNT_W-1:0]  w_count;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push_ok;
    logic              w_push;
    logic              w_advance;

    assign w_pc_inc = pc_q + ADDR_W'(1);

    // Record as it would look if the byte on rom_data is the last one.
    always_comb begin
        w_byte1    = byte1_q;
        w_imm1     = 8'h00;
        w_imm2     = 8'h00;
        w_complete = 1'b0;
        unique case (state_q)
            REG: begin
                w_byte1    = rom_data;
                w_complete = ~(rom_data[7] | rom_data[6]);
            end
            IMM1: begin
                w_imm1     = rom_data;
                w_complete = ~byte1_q[6];
            end
            IMM2: begin
                w_imm1     = byte1_q[7] ? imm1_q : 8'h00;
                w_imm2     = rom_data;
                w_complete = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_rec = build_rec(byte0_q, w_byte1, w_imm1, w_imm2,
                             CPU_ADDR_W'(start_pc_q), CPU_ADDR_W'(w_pc_inc));

    assign w_pop     = ins_valid & ins_ready & ~redirect_valid;
    assign w_push_ok = (w_count < CNT_W'(DEPTH)) | (w_full & w_pop);
    assign w_push    = ~redirect_valid & ~halt & w_complete & w_push_ok;
    // A blocked completion holds everything so the final byte is re-read.
    assign w_advance = ~halt & (~w_complete | w_push_ok);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= OP;
            pc_q       <= '0;
            start_pc_q <= '0;
            byte0_q    <= '0;
            byte1_q    <= '0;
            imm1_q     <= '0;
        end else if (redirect_valid) begin
            state_q <= OP;
            pc_q    <= redirect_pc;
        end else if (w_advance) begin
            pc_q <= w_pc_inc;
            unique case (state_q)
                OP: begin
                    byte0_q    <= rom_data;
                    start_pc_q <= pc_q;
                    state_q    <= REG;
                end
                REG: begin
                    byte1_q <= rom_data;
                    state_q <= rom_data[7] ? IMM1 : (rom_data[6] ? IMM2 : OP);
                end
                IMM1: begin
                    imm1_q  <= rom_data;
                    state_q <= byte1_q[6] ? IMM2 : OP;
                end
                default: state_q <= OP;
            endcase
        end
    end

    instr_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk     (clk),
        .rst     (rst),
        .push_i  (w_push),
        .data_i  (w_rec),
        .pop_i   (w_pop),
        .flush_i (redirect_valid),
        .head_o  (w_head),
        .count_o (w_count),
        .full_o  (w_full),
        .empty_o (w_empty)
    );

    assign rom_addr    = pc_q;
    assign ins_valid   = ~w_empty;
    assign ins_opcode  = w_head.opcode;
    assign ins_dst     = w_head.dst;
    assign ins_hasimm1 = w_head.hasimm1;
    assign ins_hasimm2 = w_head.hasimm2;
    assign ins_src1    = w_head.src1;
    assign ins_src2    = w_head.src2;
    assign ins_imm1    = w_head.imm1;
    assign ins_imm2    = w_head.imm2;
    assign ins_pc      = ADDR_W'(w_head.pc);
    assign ins_next_pc = ADDR_W'(w_head.next_pc);

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_unit
// Purpose  : Directed stimulus with a record scoreboard for instr_fetch_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_unit;
    import cpu_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        halt;
    logic        redirect_valid;
    logic [15:0] redirect_pc;
    logic        ins_ready;
    logic [15:0] rom_addr;
    logic [7:0]  rom_data;
    logic        ins_valid;
    logic [4:0]  ins_opcode;
    logic [2:0]  ins_dst;
    logic        ins_hasimm1;
    logic        ins_hasimm2;
    logic [2:0]  ins_src1;
    logic [2:0]  ins_src2;
    logic [7:0]  ins_imm1;
    logic [7:0]  ins_imm2;
    logic [15:0] ins_pc;
    logic [15:0] ins_next_pc;

    logic [7:0]  rom [0:65535];
    instr_rec_t  exp_q [$];
    int          n_cmp = 0;
    int          n_err = 0;

    assign rom_data = rom[rom_addr];

    always #5 clk = ~clk;

    instr_fetch_unit #(
        .ADDR_W (16),
        .DEPTH  (2)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .rom_addr       (rom_addr),
        .rom_data       (rom_data),
        .halt           (halt),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .ins_valid      (ins_valid),
        .ins_ready      (ins_ready),
        .ins_opcode     (ins_opcode),
        .ins_dst        (ins_dst),
        .ins_hasimm1    (ins_hasimm1),
        .ins_hasimm2    (ins_hasimm2),
        .ins_src1       (ins_src1),
        .ins_src2       (ins_src2),
        .ins_imm1       (ins_imm1),
        .ins_imm2       (ins_imm2),
        .ins_pc         (ins_pc),
        .ins_next_pc    (ins_next_pc)
    );

    function automatic instr_rec_t mk(
        input logic [4:0] opc, input logic [2:0] dst,
        input logic h1, input logic h2,
        input logic [2:0] s1, input logic [2:0] s2,
        input logic [7:0] i1, input logic [7:0] i2,
        input logic [15:0] pc, input logic [15:0] npc
    );
        instr_rec_t r;
        r.opcode = opc; r.dst = dst; r.hasimm1 = h1; r.hasimm2 = h2;
        r.src1 = s1; r.src2 = s2; r.imm1 = i1; r.imm2 = i2;
        r.pc = pc; r.next_pc = npc;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic jump(input logic [15:0] pc);
        redirect_valid = 1'b1;
        redirect_pc    = pc;
        tick();
        redirect_valid = 1'b0;
    endtask

    task automatic run(input int n);
        halt = 1'b0;
        repeat (n) tick();
        halt = 1'b1;
    endtask

    // Monitor: every accepted head must match the next expected record.
    always @(negedge clk) begin
        if (!rst && ins_valid && ins_ready && !redirect_valid) begin
            instr_rec_t act;
            instr_rec_t expv;
            act = mk(ins_opcode, ins_dst, ins_hasimm1, ins_hasimm2, ins_src1,
                     ins_src2, ins_imm1, ins_imm2, ins_pc, ins_next_pc);
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_record: got 0x%0h, expected none", act);
            end else begin
                expv = exp_q.pop_front();
                if (act !== expv) begin
                    n_err++;
                    $display("FAIL record@%0h: got 0x%0h, expected 0x%0h", expv.pc, act, expv);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 65536; i++) rom[i] = 8'h00;
        rom[16'h0000] = 8'h01; rom[16'h0001] = 8'h08;
        rom[16'h0010] = 8'h45; rom[16'h0011] = 8'h12;
        rom[16'h0020] = 8'h21; rom[16'h0021] = 8'hC0; rom[16'h0022] = 8'h05; rom[16'h0023] = 8'h07;
        rom[16'h0040] = 8'h01; rom[16'h0041] = 8'h08;
        rom[16'h0042] = 8'h02; rom[16'h0043] = 8'h10;
        rom[16'h0044] = 8'h03; rom[16'h0045] = 8'h18;
        rom[16'h0060] = 8'h01; rom[16'h0061] = 8'h08;
        rom[16'h0062] = 8'h21; rom[16'h0063] = 8'hC0; rom[16'h0064] = 8'h05; rom[16'h0065] = 8'h07;
        rom[16'h0080] = 8'h01; rom[16'h0081] = 8'h08;
        rom[16'h0082] = 8'h02; rom[16'h0083] = 8'h10;
        rom[16'h0084] = 8'h21; rom[16'h0085] = 8'hC0; rom[16'h0086] = 8'h05; rom[16'h0087] = 8'h07;
        rom[16'h00A0] = 8'h01; rom[16'h00A1] = 8'h08;
        rom[16'h00C0] = 8'h1F; rom[16'h00C1] = 8'h4A; rom[16'h00C2] = 8'h99;
        rom[16'h00C3] = 8'hE2; rom[16'h00C4] = 8'h9B; rom[16'h00C5] = 8'h5A;
        rom[16'hFFFE] = 8'h03; rom[16'hFFFF] = 8'h08;

        rst = 1'b1; halt = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; ins_ready = 1'b1;
        repeat (2) tick();
        chk("reset_rom_addr", 32'(rom_addr), 32'h0);
        chk("reset_valid", 32'(ins_valid), 32'h0);
        chk("reset_opcode", 32'(ins_opcode), 32'h0);
        chk("reset_next_pc", 32'(ins_next_pc), 32'h0);
        rst = 1'b0;

        // 2-byte instruction at 0
        exp_q.push_back(mk(5'd1, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'h00, 16'h0000, 16'h0002));
        run(2);
        chk("two_byte_valid", 32'(ins_valid), 32'h1);
        chk("two_byte_rom_addr", 32'(rom_addr), 32'h2);
        repeat (2) tick();

        // 4-byte instruction
        jump(16'h0020);
        exp_q.push_back(mk(5'd1, 3'd1, 1'b1, 1'b1, 3'd0, 3'd0, 8'h05, 8'h07, 16'h0020, 16'h0024));
        run(4);
        chk("four_byte_rom_addr", 32'(rom_addr), 32'h24);
        repeat (2) tick();

        // imm2-only and imm1-only forms
        jump(16'h00C0);
        exp_q.push_back(mk(5'd31, 3'd0, 1'b0, 1'b1, 3'd1, 3'd2, 8'h00, 8'h99, 16'h00C0, 16'h00C3));
        exp_q.push_back(mk(5'd2, 3'd7, 1'b1, 1'b0, 3'd3, 3'd3, 8'h5A, 8'h00, 16'h00C3, 16'h00C6));
        run(6);
        chk("mixed_rom_addr", 32'(rom_addr), 32'hC6);
        repeat (2) tick();

        // Backpressure with a full queue
        ins_ready = 1'b0;
        jump(16'h0040);
        exp_q.push_back(mk(5'd1, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'h00, 16'h0040, 16'h0042));
        exp_q.push_back(mk(5'd2, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 8'h00, 8'h00, 16'h0042, 16'h0044));
        exp_q.push_back(mk(5'd3, 3'd0, 1'b0, 1'b0, 3'd3, 3'd0, 8'h00, 8'h00, 16'h0044, 16'h0046));
        halt = 1'b0;
        repeat (7) tick();
        chk("bp_rom_addr_hold", 32'(rom_addr), 32'h45);
        chk("bp_valid", 32'(ins_valid), 32'h1);
        ins_ready = 1'b1;
        tick();
        ins_ready = 1'b0;
        halt = 1'b1;
        chk("bp_push_on_pop_addr", 32'(rom_addr), 32'h46);
        ins_ready = 1'b1;
        tick();
        chk("bp_count_two_remaining", 32'(ins_valid), 32'h1);
        tick();
        chk("bp_drained", 32'(ins_valid), 32'h0);
        tick();

        // Redirect during IMM1 with one queued record
        ins_ready = 1'b0;
        jump(16'h0060);
        halt = 1'b0;
        repeat (4) tick();
        redirect_valid = 1'b1;
        redirect_pc = 16'h0010;
        ins_ready = 1'b1;
        tick();
        redirect_valid = 1'b0;
        chk("redir_valid", 32'(ins_valid), 32'h0);
        chk("redir_rom_addr", 32'(rom_addr), 32'h10);
        chk("redir_head_pc_cleared", 32'(ins_pc), 32'h0);
        exp_q.push_back(mk(5'd5, 3'd2, 1'b0, 1'b0, 3'd2, 3'd2, 8'h00, 8'h00, 16'h0010, 16'h0012));
        run(2);
        repeat (2) tick();

        // PC wrap
        jump(16'hFFFE);
        exp_q.push_back(mk(5'd3, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'h00, 16'hFFFE, 16'h0000));
        run(2);
        chk("wrap_rom_addr", 32'(rom_addr), 32'h0);
        repeat (2) tick();

        // Halt mid-instruction while the queue drains
        ins_ready = 1'b0;
        jump(16'h0080);
        exp_q.push_back(mk(5'd1, 3'd0, 1'b0, 1'b0, 3'd1, 3'd0, 8'h00, 8'h00, 16'h0080, 16'h0082));
        exp_q.push_back(mk(5'd2, 3'd0, 1'b0, 1'b0, 3'd2, 3'd0, 8'h00, 8'h00, 16'h0082, 16'h0084));
        run(6);
        chk("halt_rom_addr", 32'(rom_addr), 32'h86);
        ins_ready = 1'b1;
        repeat (3) tick();
        chk("halt_rom_addr_frozen", 32'(rom_addr), 32'h86);
        chk("halt_drained", 32'(ins_valid), 32'h0);
        exp_q.push_back(mk(5'd1, 3'd1, 1'b1, 1'b1, 3'd0, 3'd0, 8'h05, 8'h07, 16'h0084, 16'h0088));
        run(2);
        repeat (2) tick();

        // Asynchronous reset while in REG
        jump(16'h00A0);
        halt = 1'b0;
        tick();
        #2 rst = 1'b1;
        #1;
        chk("async_rst_rom_addr", 32'(rom_addr), 32'h0);
        chk("async_rst_valid", 32'(ins_valid), 32'h0);
        tick();
        halt = 1'b1;
        rst = 1'b0;
        repeat (2) tick();
        chk("post_rst_no_record", 32'(ins_valid), 32'h0);
        chk("scoreboard_empty", 32'(exp_q.size()), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Upstream fetch/assemble stage for the 8-bit-byte-stream CPU core.
- Walks the byte-wide instruction ROM and assembles each variable-length instruction (opcode byte, reg byte, optional imm1, optional imm2) into one decoded record.
- Buffers records in a small queue and hands them to the execute stage over a valid/ready handshake.
- Takes a redirect from execute on taken jumps, cal and ret, and a halt input.

Parameters:
- ADDR_W, 16, ROM byte address width; fetch PC width.
- DEPTH, 2, instruction queue entries (power of two, >=1).

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  asynchronous, active-high reset.
- rom_addr  out  ADDR_W  byte address to combinational ROM (equals fetch PC).
- rom_data  in  8  byte at rom_addr, same cycle.
- halt  in  1  level; freezes fetch while high, queue still drains.
- redirect_valid  in  1  flush and restart fetch.
- redirect_pc  in  ADDR_W  new fetch address.
- ins_valid  out  1  queue head valid.
- ins_ready  in  1  execute consumes head when valid&ready.
- ins_opcode  out  5  ROM byte0[4:0].
- ins_dst  out  3  byte0[7:5].
- ins_hasimm1  out  1  byte1[7].
- ins_hasimm2  out  1  byte1[6].
- ins_src1  out  3  byte1[5:3].
- ins_src2  out  3  byte1[2:0].
- ins_imm1  out  8  imm1 byte, 0 if absent.
- ins_imm2  out  8  imm2 byte, 0 if absent.
- ins_pc  out  ADDR_W  address of the opcode byte.
- ins_next_pc  out  ADDR_W  address after the last byte (cal return value).

Behaviour:
- Reset (async, rst=1): fetch PC=0, state=OP, queue empty, ins_valid=0, all ins_* fields=0, partial registers=0.
- Assembler states: OP, REG, IMM1, IMM2. One ROM byte is captured per clk while not halted.
- OP: latch byte0 and start_pc=PC, PC+=1, go to REG.
- REG: latch byte1, PC+=1. Go to IMM1 if bit7 is set, else IMM2 if bit6 is set, else complete.
- IMM1: latch imm1, PC+=1. Go to IMM2 if hasimm2, else complete.
- IMM2: latch imm2, PC+=1, complete.
- Completion: on the edge capturing the final byte, push the record to the queue tail with next_pc=PC+1. State returns to OP.
- Push is allowed if count<DEPTH, or if count==DEPTH and a pop occurs this same cycle.
- If the push is blocked: state, PC and partial registers hold, and the final byte is re-captured next cycle. rom_addr stays stable.
- Latency: ins_valid rises the cycle after the completing edge (empty queue). Instruction lengths are 2, 3 or 4 cycles. Sustained throughput is one instruction per length cycles.
- Pop: valid&ready advances the queue head. Simultaneous push and pop keeps count unchanged.
- Redirect: highest priority. On the edge where redirect_valid=1:
  - queue cleared, any pop that cycle ignored, partial instruction discarded;
  - state=OP, PC=redirect_pc.
  - ins_valid=0 the next cycle.
- Halt: state and PC frozen, no push. Pops still honoured. Redirect still honoured while halted.
- PC arithmetic is modulo 2^ADDR_W: 0xFFFF+1 = 0x0000, also for next_pc.
- ins_* fields are driven from the queue head. Their values are don't-care when ins_valid=0, but deterministic (last head contents, 0 after reset/flush).
- Reset asserted mid-instruction: immediate return to reset state. No partial record is ever pushed.

Decomposition:
- Shared package (cpu_pkg): FetchState enum {OP, REG, IMM1, IMM2}.
- Also in cpu_pkg: packed instr_rec_t {opcode, dst, hasimm1, hasimm2, src1, src2, imm1, imm2, pc, next_pc}; OPC_HLT=5'b11111.
- One sub-module: instr_queue (DEPTH-entry FIFO of instr_rec_t with push/pop/flush, count, full/empty).

Test Plan:
- ROM 0x00:01,0x08 (2-byte mov-style), ins_ready=1 -> ins_valid at cycle 3: opcode=1, dst=0, src1=1, src2=0, hasimm1=0, imm1=0, ins_pc=0, ins_next_pc=2.
- ROM 0x00:21,0xC0,0x05,0x07 -> one record: opcode=1, dst=1, hasimm1=1, hasimm2=1, imm1=5, imm2=7, ins_pc=0, ins_next_pc=4; next fetch from 4.
- Backpressure: ins_ready=0, three 2-byte instructions, DEPTH=2 -> two records queued, rom_addr holds at 5 (final byte of third). Raise ins_ready for one cycle -> third pushed the same edge, count stays 2.
- Redirect mid-instruction: redirect_valid with redirect_pc=0x0010 while state=IMM1 and queue holds 1 -> next cycle ins_valid=0, rom_addr=0x0010, first new record has ins_pc=0x0010.
- Wrap: redirect_pc=0xFFFE, 2-byte instruction -> ins_pc=0xFFFE, ins_next_pc=0x0000, next rom_addr=0x0000.
- Halt and reset: halt=1 mid-instruction -> rom_addr constant and queue drains. Assert rst while in REG -> ins_valid=0 and rom_addr=0 asynchronously, with no record emitted.
